// File: rtl/int_ctrl_pkg.sv
// Shared types and helpers for the interrupt controller.
//   int_state_t  : arbitration/service state of the controller
//   ID_W         : default width of interrupt ID buses
//   prio_encode  : index of the lowest set bit of a 32-bit request vector
package int_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND    = 2'd1,
      SERVICE = 2'd2
   } int_state_t;

   localparam int ID_W = 5;

   // Lowest index wins; returns 0 when no bit is set (callers gate on |req).
   function automatic logic [4:0] prio_encode(input logic [31:0] req);
      logic [4:0] idx;
      idx = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (req[i]) begin
            idx = 5'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source input conditioning: two-flop synchroniser followed by a
// rising-edge detector.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   irq_i  : raw asynchronous request
//   edge_o : one-cycle pulse, high during the cycle after sync2 first sees 1
module irq_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic irq_i,
   output logic edge_o
);

   logic sync1_q;
   logic sync2_q;
   logic sync2_dly_q;

   // Synchroniser chain plus one delay stage for edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync2_dly_q <= 1'b0;
      end else begin
         sync1_q     <= irq_i;
         sync2_q     <= sync1_q;
         sync2_dly_q <= sync2_q;
      end
   end

   assign edge_o = sync2_q & ~sync2_dly_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches edge-triggered requests into a pending
// register, arbitrates lowest-index-first among enabled sources and presents
// one request at a time to the Control_Unit (no nesting).
//   clk, rst (async active-low)
//   irq_in                      raw requests, rising-edge triggered
//   mask_we / mask_wdata        enable mask write
//   ack_start / ack_start_id    ISR entry for the presented ID
//   ack_end / ack_end_id        ISR exit for the serviced ID
//   int_flags_sw_clr            clear pending bit of current_int_id
//   int_flag, current_int_id    presentation to the Control_Unit
//   pending, mask               status readback
module interrupt_controller #(
   parameter int                 NUM_SRC    = 8,
   parameter int                 ID_W       = 5,
   parameter logic [NUM_SRC-1:0] RESET_MASK = '1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   input  logic               ack_start,
   input  logic [ID_W-1:0]    ack_start_id,
   input  logic               ack_end,
   input  logic [ID_W-1:0]    ack_end_id,
   input  logic               int_flags_sw_clr,
   output logic               int_flag,
   output logic [ID_W-1:0]    current_int_id,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] mask
);

   import int_ctrl_pkg::*;

   logic [NUM_SRC-1:0] edge_s;
   logic [NUM_SRC-1:0] pending_q;
   logic [NUM_SRC-1:0] pending_d;
   logic [NUM_SRC-1:0] mask_q;
   logic [NUM_SRC-1:0] pend_masked_s;
   logic [NUM_SRC-1:0] cur_onehot_s;
   logic [NUM_SRC-1:0] clr_s;
   logic [31:0]        req_s;
   logic [ID_W-1:0]    sel_id_s;
   logic [ID_W-1:0]    cur_id_q;
   logic               int_flag_q;
   logic               start_hit_s;
   logic               end_hit_s;
   int_state_t         state_q;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      irq_sync_edge u_sync (
         .clk_i  (clk),
         .rst_ni (rst),
         .irq_i  (irq_in[g]),
         .edge_o (edge_s[g])
      );
   end

   // Arbitration, handshake matching and pending next-state.
   always_comb begin
      pend_masked_s = pending_q & mask_q;
      req_s = 32'd0;
      req_s[NUM_SRC-1:0] = pend_masked_s;
      sel_id_s = ID_W'(prio_encode(req_s));
      // ack_start only counts when the FSM will actually take it (something
      // still enabled and pending), so pending is never cleared without SERVICE.
      start_hit_s = (state_q == PEND) && (pend_masked_s != '0) &&
                    ack_start && (ack_start_id == cur_id_q);
      end_hit_s   = (state_q == SERVICE) && ack_end && (ack_end_id == cur_id_q);
      // IDs >= NUM_SRC decode to no bit, making sw_clr a no-op for them.
      for (int i = 0; i < NUM_SRC; i++) begin
         cur_onehot_s[i] = (cur_id_q == ID_W'(i));
      end
      clr_s = (start_hit_s ? cur_onehot_s : '0) |
              (int_flags_sw_clr ? cur_onehot_s : '0);
      // Set wins over clear so a coincident new edge is never lost.
      pending_d = (pending_q & ~clr_s) | edge_s;
   end

   // Pending and enable-mask registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q <= '0;
         mask_q    <= RESET_MASK;
      end else begin
         pending_q <= pending_d;
         if (mask_we) begin
            mask_q <= mask_wdata;
         end
      end
   end

   // Presentation/service FSM with registered flag and ID.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         int_flag_q <= 1'b0;
         cur_id_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pend_masked_s != '0) begin
                  state_q    <= PEND;
                  cur_id_q   <= sel_id_s;
                  int_flag_q <= 1'b1;
               end
            end
            PEND: begin
               if (pend_masked_s == '0) begin
                  state_q    <= IDLE;
                  int_flag_q <= 1'b0;
               end else if (start_hit_s) begin
                  state_q    <= SERVICE;
                  int_flag_q <= 1'b0;
               end else begin
                  // Re-arbitrate every cycle so higher priority preempts.
                  cur_id_q <= sel_id_s;
               end
            end
            SERVICE: begin
               if (end_hit_s) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               int_flag_q <= 1'b0;
            end
         endcase
      end
   end

   assign int_flag       = int_flag_q;
   assign current_int_id = cur_id_q;
   assign pending        = pending_q;
   assign mask           = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

   localparam int N  = 8;
   localparam int IW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  irq_in;
   logic          mask_we;
   logic [N-1:0]  mask_wdata;
   logic          ack_start;
   logic [IW-1:0] ack_start_id;
   logic          ack_end;
   logic [IW-1:0] ack_end_id;
   logic          int_flags_sw_clr;
   logic          int_flag;
   logic [IW-1:0] current_int_id;
   logic [N-1:0]  pending;
   logic [N-1:0]  mask;

   always #5 clk = ~clk;

   interrupt_controller #(.NUM_SRC(N), .ID_W(IW), .RESET_MASK({N{1'b1}})) dut (
      .clk              (clk),
      .rst              (rst),
      .irq_in           (irq_in),
      .mask_we          (mask_we),
      .mask_wdata       (mask_wdata),
      .ack_start        (ack_start),
      .ack_start_id     (ack_start_id),
      .ack_end          (ack_end),
      .ack_end_id       (ack_end_id),
      .int_flags_sw_clr (int_flags_sw_clr),
      .int_flag         (int_flag),
      .current_int_id   (current_int_id),
      .pending          (pending),
      .mask             (mask)
   );

   typedef struct {
      bit       flag;
      int       id;
      bit [N-1:0] pend;
      bit [N-1:0] msk;
   } exp_t;

   exp_t sb_q[$];
   int errors = 0;
   int checks = 0;

   // Reference model: sampled-input history, pending set, and a
   // presentation / in-service description of the controller.
   bit [N-1:0] m_pend, m_mask;
   bit [N-1:0] h0, h1, h2;   // irq_in sampled at the last three edges
   bit         m_show;       // a request is currently presented
   int         m_svc;        // ID in service, -1 when none
   int         m_cur;        // ID on current_int_id

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lowest(input bit [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '1;
      h0 = '0; h1 = '0; h2 = '0;
      m_show = 1'b0; m_svc = -1; m_cur = 0;
   endtask

   // Predict the next edge from current inputs, queue it, advance one cycle.
   task automatic tick();
      exp_t e;
      bit [N-1:0] act, ev, clr;
      int old_cur;
      if (!rst) begin
         model_reset();
      end else begin
         act = m_pend & m_mask;
         // a request sampled high after being sampled low sets pending two edges later
         ev = h1 & ~h2;
         h2 = h1; h1 = h0; h0 = irq_in;
         clr = '0;
         old_cur = m_cur;
         if (m_svc >= 0) begin
            if (ack_end && int'(ack_end_id) == m_cur) m_svc = -1;
         end else if (m_show) begin
            if (act == '0) m_show = 1'b0;
            else if (ack_start && int'(ack_start_id) == m_cur) begin
               m_show = 1'b0; m_svc = m_cur; clr[m_cur] = 1'b1;
            end else m_cur = lowest(act);
         end else if (act != '0) begin
            m_show = 1'b1; m_cur = lowest(act);
         end
         if (int_flags_sw_clr && old_cur < N) clr[old_cur] = 1'b1;
         m_pend = (m_pend & ~clr) | ev;
         if (mask_we) m_mask = mask_wdata;
      end
      e.flag = m_show; e.id = m_cur; e.pend = m_pend; e.msk = m_mask;
      sb_q.push_back(e);
      @(negedge clk);
      ack_start = 1'b0; ack_end = 1'b0; int_flags_sw_clr = 1'b0; mask_we = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst_flag", int_flag, 0);
      chk("rst_pending", pending, 0);
      chk("rst_mask", mask, 32'hFF);
      chk("rst_id", current_int_id, 0);
      ticks(2);
      rst = 1'b1;
   endtask

   // Monitor: compare every registered output update against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_flag", int_flag, e.flag);
            chk("sb_id", current_int_id, e.id);
            chk("sb_pending", pending, e.pend);
            chk("sb_mask", mask, e.msk);
         end
      end
   end

   task automatic random_run(input int n);
      bit [N-1:0] t;
      for (int c = 0; c < n; c++) begin
         t = '0;
         for (int i = 0; i < N; i++) if ($urandom_range(11) == 0) t[i] = 1'b1;
         irq_in = irq_in ^ t;
         if ($urandom_range(3) == 0) begin
            ack_start = 1'b1;
            ack_start_id = ($urandom_range(3) != 0) ? IW'(m_cur) : IW'($urandom_range(31));
         end
         if ($urandom_range(3) == 0) begin
            ack_end = 1'b1;
            ack_end_id = ($urandom_range(3) != 0) ? IW'(m_cur) : IW'($urandom_range(31));
         end
         if ($urandom_range(15) == 0) int_flags_sw_clr = 1'b1;
         if ($urandom_range(31) == 0) begin
            mask_we = 1'b1;
            mask_wdata = N'($urandom) | N'($urandom);
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
      ack_start = 1'b0; ack_start_id = '0; ack_end = 1'b0; ack_end_id = '0;
      int_flags_sw_clr = 1'b0;
      @(negedge clk);
      do_reset();

      // single request: pending at edge+2, flag/id at edge+3
      irq_in[3] = 1'b1;
      ticks(3);
      chk("t2_pend3", pending[3], 1);
      chk("t2_flag_early", int_flag, 0);
      tick();
      chk("t2_flag", int_flag, 1);
      chk("t2_id", current_int_id, 3);

      // mismatched acks are ignored
      ack_start = 1'b1; ack_start_id = 5'd7; tick();
      chk("t4_bad_start_flag", int_flag, 1);
      ack_start = 1'b1; ack_start_id = 5'd3; tick();
      chk("t4_svc_flag", int_flag, 0);
      chk("t4_svc_pend3", pending[3], 0);
      ack_end = 1'b1; ack_end_id = 5'd4; tick();
      chk("t4_bad_end_id", current_int_id, 3);
      ack_end = 1'b1; ack_end_id = 5'd3; tick();
      tick();
      chk("t4_idle_flag", int_flag, 0);
      irq_in[3] = 1'b0;

      // preemption by a higher-priority arrival while presenting
      irq_in[5] = 1'b1; ticks(4);
      chk("t3_id5", current_int_id, 5);
      irq_in[2] = 1'b1; ticks(3);
      chk("t3_still5", current_int_id, 5);
      tick();
      chk("t3_id2", current_int_id, 2);
      ack_start = 1'b1; ack_start_id = 5'd2; tick();
      chk("t3_svc2_flag", int_flag, 0);
      ack_end = 1'b1; ack_end_id = 5'd2; tick();
      tick();
      chk("t3_next_flag", int_flag, 1);
      chk("t3_next_id", current_int_id, 5);
      ack_start = 1'b1; ack_start_id = 5'd5; tick();
      ack_end = 1'b1; ack_end_id = 5'd5; tick();
      tick();
      irq_in[5] = 1'b0; irq_in[2] = 1'b0;
      ticks(2);

      // masking withdraws the request without clearing pending
      irq_in[3] = 1'b1; ticks(4);
      chk("t5_id3", current_int_id, 3);
      mask_we = 1'b1; mask_wdata = '0; ticks(2);
      chk("t5_masked_flag", int_flag, 0);
      chk("t5_masked_pend3", pending[3], 1);
      mask_we = 1'b1; mask_wdata = '1; ticks(2);
      chk("t5_unmask_flag", int_flag, 1);
      chk("t5_unmask_id", current_int_id, 3);

      // edge coincident with ack_start re-pends; sw_clr withdraws
      irq_in[3] = 1'b0; ticks(3);
      irq_in[3] = 1'b1; ticks(2);
      ack_start = 1'b1; ack_start_id = 5'd3; tick();
      chk("t6_svc_flag", int_flag, 0);
      chk("t6_repend3", pending[3], 1);
      ack_end = 1'b1; ack_end_id = 5'd3; ticks(2);
      chk("t6_again_flag", int_flag, 1);
      chk("t6_again_id", current_int_id, 3);
      int_flags_sw_clr = 1'b1; ticks(2);
      chk("t6_swclr_pend3", pending[3], 0);
      chk("t6_swclr_flag", int_flag, 0);

      random_run(1500);

      // mid-run reset with a non-default mask and activity in flight
      mask_we = 1'b1; mask_wdata = 8'h0F; irq_in = irq_in ^ 8'h0F; tick();
      tick();
      do_reset();

      random_run(1500);
      ticks(2);

      chk("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
